// File: rtl/vga_stream_gen_pkg.sv
// Shared stream definitions: bit-field positions of the 26-bit RGB stream and
// the default 640x480@60 timing used by every stream stage.
package vga_stream_gen_pkg;

  localparam int VGA_W   = 26;
  localparam int CNT_W   = 10;

  localparam int ACTIVE_BIT = 0;
  localparam int VS_BIT     = 1;
  localparam int HS_BIT     = 2;
  localparam int YC_LSB     = 3;
  localparam int YC_MSB     = 12;
  localparam int XC_LSB     = 13;
  localparam int XC_MSB     = 22;
  localparam int R_BIT      = 23;
  localparam int G_BIT      = 24;
  localparam int B_BIT      = 25;
  localparam int RGB_LSB    = R_BIT;
  localparam int RGB_MSB    = B_BIT;

  // Idle word: syncs deasserted (high), everything else zero.
  localparam logic [VGA_W-1:0] VGA_IDLE = 26'h0000006;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [2:0] rgb_t;   // {B,G,R}

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_GRID    = 2'd3
  } pattern_e;

endpackage

// File: rtl/vga_stream_gen_if.sv
// Output side of the timing generator: pixel stream word plus frame markers.
interface vga_stream_gen_if;
  import vga_stream_gen_pkg::*;

  logic [VGA_W-1:0] strRGB_o;
  logic             frame_start_o;
  logic [7:0]       frame_cnt_o;

  modport master (output strRGB_o, output frame_start_o, output frame_cnt_o);
  modport slave  (input  strRGB_o, input  frame_start_o, input  frame_cnt_o);

endinterface

// File: rtl/vga_stream_gen_pattern_gen.sv
// Test-pattern colour from raw counters; purely combinational, black outside
// the active area.
module vga_stream_gen_pattern_gen
  import vga_stream_gen_pkg::*;
(
  input  logic [CNT_W-1:0] h_cnt,
  input  logic [CNT_W-1:0] v_cnt,
  input  logic             active,
  input  logic [1:0]       pattern_sel,
  input  rgb_t             bg_color,
  output rgb_t             rgb
);

  pattern_e pat;
  logic     unused_cnt_bits;

  assign pat             = pattern_e'(pattern_sel);
  assign unused_cnt_bits = ^{h_cnt[6:4], v_cnt[CNT_W-1:4]};

  always_comb begin
    rgb = '0;
    if (active) begin
      case (pat)
        PAT_SOLID:   rgb = bg_color;
        // 128-pixel bars straight from the top counter bits
        PAT_BARS:    rgb = h_cnt[CNT_W-1 -: 3];
        PAT_CHECKER: rgb = (h_cnt[3] ^ v_cnt[3]) ? ~bg_color : bg_color;
        PAT_GRID:    rgb = ((h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0)) ? 3'b111 : bg_color;
        default:     rgb = bg_color;
      endcase
    end
  end

endmodule

// File: rtl/vga_stream_gen.sv
// VGA timing + test-pattern stream source; all outputs registered, one cycle
// behind the counters. en=0 freezes every register and suppresses frame_start_o.
module vga_stream_gen
  import vga_stream_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             px_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       bg_color,
  input  logic [1:0]       pattern_sel,
  vga_stream_gen_if.master strm
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hs;
  logic             vs;
  logic             first_px;
  rgb_t             rgb;
  logic [VGA_W-1:0] pix_nxt;

  assign active   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign first_px = (h_cnt == '0) && (v_cnt == '0);

  vga_stream_gen_pattern_gen pattern_gen (
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .pattern_sel (pattern_sel),
    .bg_color    (bg_color),
    .rgb         (rgb)
  );

  always_comb begin
    pix_nxt                   = '0;
    pix_nxt[RGB_MSB:RGB_LSB]  = rgb;
    pix_nxt[XC_MSB:XC_LSB]    = h_cnt;
    pix_nxt[YC_MSB:YC_LSB]    = v_cnt;
    pix_nxt[HS_BIT]           = hs;
    pix_nxt[VS_BIT]           = vs;
    pix_nxt[ACTIVE_BIT]       = active;
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt              <= '0;
      v_cnt              <= '0;
      strm.strRGB_o      <= VGA_IDLE;
      strm.frame_start_o <= 1'b0;
      strm.frame_cnt_o   <= 8'd0;
    end else if (en) begin
      strm.strRGB_o      <= pix_nxt;
      strm.frame_start_o <= first_px;
      // counter bumps together with the pulse so they read consistently
      if (first_px) begin
        strm.frame_cnt_o <= strm.frame_cnt_o + 8'd1;
      end
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end else begin
      strm.frame_start_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Bench for vga_stream_gen: full-size instance for line/pattern checks, a tiny
// mode instance for frame-level and counter-wrap checks, plus a stream model.
module tb_vga_stream_gen;
  import vga_stream_gen_pkg::*;

  localparam int HA  [2] = '{640, 8};
  localparam int HF  [2] = '{16, 2};
  localparam int HSY [2] = '{96, 3};
  localparam int HB  [2] = '{48, 3};
  localparam int VA  [2] = '{480, 4};
  localparam int VF  [2] = '{10, 1};
  localparam int VSY [2] = '{2, 2};
  localparam int VB  [2] = '{33, 1};

  logic       px_clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] bg_color;
  logic [1:0] pattern_sel;

  int n_cmp = 0;
  int n_err = 0;

  vga_stream_gen_if big_if ();
  vga_stream_gen_if sml_if ();

  vga_stream_gen u_big (
    .px_clk      (px_clk),
    .reset_n     (reset_n),
    .en          (en),
    .bg_color    (bg_color),
    .pattern_sel (pattern_sel),
    .strm        (big_if.master)
  );

  vga_stream_gen #(
    .H_ACTIVE (HA[1]), .H_FP (HF[1]), .H_SYNC (HSY[1]), .H_BP (HB[1]),
    .V_ACTIVE (VA[1]), .V_FP (VF[1]), .V_SYNC (VSY[1]), .V_BP (VB[1])
  ) u_sml (
    .px_clk      (px_clk),
    .reset_n     (reset_n),
    .en          (en),
    .bg_color    (bg_color),
    .pattern_sel (pattern_sel),
    .strm        (sml_if.master)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int xc_of(input logic [VGA_W-1:0] p);
    return int'(p[XC_MSB:XC_LSB]);
  endfunction

  function automatic int yc_of(input logic [VGA_W-1:0] p);
    return int'(p[YC_MSB:YC_LSB]);
  endfunction

  // ---------------- stream model + scoreboard ----------------
  typedef struct packed {
    logic [VGA_W-1:0] pix;
    logic             fs;
    logic [7:0]       fc;
  } obs_t;

  typedef struct packed {
    obs_t big;
    obs_t sml;
  } pair_t;

  pair_t            sb_q[$];
  int               mh  [2];
  int               mv  [2];
  logic [7:0]       mfc [2];
  logic [VGA_W-1:0] mout[2];

  function automatic logic [VGA_W-1:0] exp_pix(input int k, input int h, input int v,
                                                input logic [2:0] bg, input logic [1:0] ps);
    logic [9:0] hb;
    logic [9:0] vb;
    logic [2:0] c;
    logic       act;
    logic       hsn;
    logic       vsn;
    hb  = h[9:0];
    vb  = v[9:0];
    act = (h < HA[k]) && (v < VA[k]);
    hsn = !((h >= HA[k] + HF[k]) && (h < HA[k] + HF[k] + HSY[k]));
    vsn = !((v >= VA[k] + VF[k]) && (v < VA[k] + VF[k] + VSY[k]));
    case (ps)
      2'd0:    c = bg;
      2'd1:    c = hb[9:7];
      2'd2:    c = (hb[3] != vb[3]) ? ~bg : bg;
      default: c = ((hb[3:0] == 4'd0) || (vb[3:0] == 4'd0)) ? 3'b111 : bg;
    endcase
    if (!act) c = 3'b000;
    return {c, hb, vb, hsn, vsn, act};
  endfunction

  always @(posedge px_clk or negedge reset_n) begin : model_step
    obs_t o[2];
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mh[k] = 0; mv[k] = 0; mfc[k] = 8'd0; mout[k] = 26'h0000006;
      end
      sb_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        o[k].fs = 1'b0;
        if (en) begin
          o[k].fs = (mh[k] == 0) && (mv[k] == 0);
          if (o[k].fs) mfc[k] = mfc[k] + 8'd1;
          mout[k] = exp_pix(k, mh[k], mv[k], bg_color, pattern_sel);
          mh[k]++;
          if (mh[k] == HA[k] + HF[k] + HSY[k] + HB[k]) begin
            mh[k] = 0;
            mv[k]++;
            if (mv[k] == VA[k] + VF[k] + VSY[k] + VB[k]) mv[k] = 0;
          end
        end
        o[k].pix = mout[k];
        o[k].fc  = mfc[k];
      end
      sb_q.push_back({o[0], o[1]});
    end
  end

  always @(negedge px_clk) begin : sb_check
    pair_t e;
    if (reset_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_big", {big_if.strRGB_o, big_if.frame_start_o, big_if.frame_cnt_o}, e.big);
      check("sb_sml", {sml_if.strRGB_o, sml_if.frame_start_o, sml_if.frame_cnt_o}, e.sml);
    end
  end

  // ---------------- directed sequences ----------------
  typedef struct {
    int         x;
    int         y;
    logic [1:0] ps;
    logic [2:0] bg;
    logic [2:0] rgb;
    logic       act;
  } vec_t;

  vec_t tv[19];

  task automatic wait_pix(input int x, input int y, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge px_clk);
      if (xc_of(big_if.strRGB_o) == x && yc_of(big_if.strRGB_o) == y) ok = 1'b1;
    end
  endtask

  initial begin : main
    bit ok;
    int hs_lo, act_n, first_hs, last_xc, last_yc;
    int vs_lo, vmin, vmax, early, nfs, prev_fc;
    bit wrapped;

    tv[0]  = '{5,   1,  2'd1, 3'b000, 3'b000, 1'b1};
    tv[1]  = '{127, 1,  2'd1, 3'b000, 3'b000, 1'b1};
    tv[2]  = '{128, 1,  2'd1, 3'b000, 3'b001, 1'b1};
    tv[3]  = '{300, 1,  2'd1, 3'b000, 3'b010, 1'b1};
    tv[4]  = '{512, 1,  2'd1, 3'b000, 3'b100, 1'b1};
    tv[5]  = '{639, 1,  2'd1, 3'b000, 3'b100, 1'b1};
    tv[6]  = '{640, 1,  2'd1, 3'b000, 3'b000, 1'b0};
    tv[7]  = '{0,   2,  2'd2, 3'b011, 3'b011, 1'b1};
    tv[8]  = '{8,   2,  2'd2, 3'b011, 3'b100, 1'b1};
    tv[9]  = '{16,  2,  2'd2, 3'b011, 3'b011, 1'b1};
    tv[10] = '{0,   9,  2'd2, 3'b011, 3'b100, 1'b1};
    tv[11] = '{8,   9,  2'd2, 3'b011, 3'b011, 1'b1};
    tv[12] = '{5,   16, 2'd3, 3'b001, 3'b111, 1'b1};
    tv[13] = '{0,   17, 2'd3, 3'b001, 3'b111, 1'b1};
    tv[14] = '{5,   17, 2'd3, 3'b001, 3'b001, 1'b1};
    tv[15] = '{16,  17, 2'd3, 3'b001, 3'b111, 1'b1};
    tv[16] = '{700, 17, 2'd3, 3'b001, 3'b000, 1'b0};
    tv[17] = '{10,  18, 2'd0, 3'b110, 3'b110, 1'b1};
    tv[18] = '{645, 18, 2'd0, 3'b110, 3'b000, 1'b0};

    reset_n = 1'b1; en = 1'b1; bg_color = 3'b010; pattern_sel = 2'd0;
    #1 reset_n = 1'b0;
    #11;
    check("rst_big_pix", big_if.strRGB_o, 26'h0000006);
    check("rst_big_fs",  big_if.frame_start_o, 1'b0);
    check("rst_big_fc",  big_if.frame_cnt_o, 8'd0);
    check("rst_sml_pix", sml_if.strRGB_o, 26'h0000006);
    #1 reset_n = 1'b1;
    @(negedge px_clk);
    check("first_big_pix", big_if.strRGB_o, 26'h1000007);
    check("first_big_fs",  big_if.frame_start_o, 1'b1);
    check("first_big_fc",  big_if.frame_cnt_o, 8'd1);
    check("first_sml_fc",  sml_if.frame_cnt_o, 8'd1);

    // one full line of the 640x480 instance
    hs_lo = 0; act_n = 0; first_hs = -1; last_xc = -1; last_yc = -1;
    for (int i = 0; i < 800; i++) begin
      if (!big_if.strRGB_o[HS_BIT]) begin
        if (hs_lo == 0) first_hs = xc_of(big_if.strRGB_o);
        hs_lo++;
      end
      if (big_if.strRGB_o[ACTIVE_BIT]) act_n++;
      last_xc = xc_of(big_if.strRGB_o);
      last_yc = yc_of(big_if.strRGB_o);
      @(negedge px_clk);
    end
    check("line_hs_low",   hs_lo, 96);
    check("line_hs_first", first_hs, 656);
    check("line_active",   act_n, 640);
    check("line_last_xc",  last_xc, 799);
    check("line_last_yc",  last_yc, 0);
    check("wrap_xc", xc_of(big_if.strRGB_o), 0);
    check("wrap_yc", yc_of(big_if.strRGB_o), 1);

    for (int i = 0; i < 19; i++) begin
      pattern_sel = tv[i].ps;
      bg_color    = tv[i].bg;
      wait_pix(tv[i].x, tv[i].y, 20000, ok);
      check($sformatf("tv%0d_found", i), ok, 1'b1);
      if (ok) begin
        check($sformatf("tv%0d_rgb", i), big_if.strRGB_o[RGB_MSB:RGB_LSB], tv[i].rgb);
        check($sformatf("tv%0d_act", i), big_if.strRGB_o[ACTIVE_BIT], tv[i].act);
      end
    end

    // freeze for 10 edges while showing XC=100
    wait_pix(100, 19, 2000, ok);
    check("frz_found", ok, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge px_clk);
      check($sformatf("frz%0d_xc", i), xc_of(big_if.strRGB_o), 100);
      check($sformatf("frz%0d_fs", i), big_if.frame_start_o | sml_if.frame_start_o, 1'b0);
    end
    en = 1'b1;
    @(negedge px_clk);
    check("frz_resume_xc", xc_of(big_if.strRGB_o), 101);
    check("frz_resume_yc", yc_of(big_if.strRGB_o), 19);

    // frame-level timing on the small mode (16 x 8 totals)
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge px_clk);
      if (sml_if.frame_start_o) ok = 1'b1;
    end
    check("sml_fs_found", ok, 1'b1);
    vs_lo = 0; hs_lo = 0; vmin = 999; vmax = -1; early = 0;
    for (int i = 1; i <= 128; i++) begin
      if (!sml_if.strRGB_o[VS_BIT]) begin
        vs_lo++;
        if (yc_of(sml_if.strRGB_o) < vmin) vmin = yc_of(sml_if.strRGB_o);
        if (yc_of(sml_if.strRGB_o) > vmax) vmax = yc_of(sml_if.strRGB_o);
      end
      if (!sml_if.strRGB_o[HS_BIT]) hs_lo++;
      @(negedge px_clk);
      if (i < 128 && sml_if.frame_start_o) early++;
    end
    check("sml_vs_low",  vs_lo, 32);
    check("sml_hs_low",  hs_lo, 24);
    check("sml_vs_min",  vmin, 5);
    check("sml_vs_max",  vmax, 6);
    check("sml_fs_early", early, 0);
    check("sml_fs_period", sml_if.frame_start_o, 1'b1);

    // asynchronous reset mid-frame, released before the next edge
    wait_pix(300, 20, 2000, ok);
    check("mrst_found", ok, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_big_pix", big_if.strRGB_o, 26'h0000006);
    check("mrst_big_fs",  big_if.frame_start_o, 1'b0);
    check("mrst_big_fc",  big_if.frame_cnt_o, 8'd0);
    check("mrst_sml_fc",  sml_if.frame_cnt_o, 8'd0);
    #1 reset_n = 1'b1;
    @(negedge px_clk);
    check("mrst_first_pix", big_if.strRGB_o, 26'h3000007);
    check("mrst_first_fs",  big_if.frame_start_o, 1'b1);
    check("mrst_first_fc",  big_if.frame_cnt_o, 8'd1);
    check("mrst_sml_fc1",   sml_if.frame_cnt_o, 8'd1);

    // frame counter wrap on the small mode
    nfs = 0; prev_fc = int'(sml_if.frame_cnt_o); wrapped = 1'b0;
    for (int c = 0; c < 40000 && !wrapped; c++) begin
      @(negedge px_clk);
      if (sml_if.frame_start_o) nfs++;
      if (sml_if.frame_cnt_o == 8'd0) begin
        wrapped = 1'b1;
        check("wrap_prev_fc", prev_fc, 255);
        check("wrap_fs", sml_if.frame_start_o, 1'b1);
      end
      prev_fc = int'(sml_if.frame_cnt_o);
    end
    check("wrap_seen", wrapped, 1'b1);
    check("wrap_frames", nfs, 255);
    check("wrap_big_fc", big_if.frame_cnt_o, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
